// File: rtl/baccarat_pkg.sv
// ============================================================================
// Module : baccarat_pkg
// Brief  : Shared state encoding, default rule thresholds and card helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package baccarat_pkg;

  typedef enum logic [3:0] {
    IDLE, P1, D1, P2, D2, EVAL, P3, BCHK, D3, DONE
  } state_t;

  localparam int NAT_MIN_DEF  = 8;
  localparam int DRAW_MAX_DEF = 5;

  // Tens and face cards count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction

endpackage

`default_nettype wire

// File: rtl/banker_draw_rule.sv
// ============================================================================
// Module : banker_draw_rule
// Brief  : Banker third-card tableau: dealer two-card score and player third card -> draw.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] i_dscore,
  input  logic [3:0] i_pcard3,
  output logic       o_draw
);

  logic [3:0] w_v;

  always_comb begin
    w_v    = card_value(i_pcard3);
    o_draw = 1'b0;
    case (i_dscore)
      4'd0, 4'd1, 4'd2: o_draw = 1'b1;
      4'd3:             o_draw = (w_v != 4'd8);
      4'd4:             o_draw = (w_v >= 4'd2) && (w_v <= 4'd7);
      4'd5:             o_draw = (w_v >= 4'd4) && (w_v <= 4'd7);
      4'd6:             o_draw = (w_v >= 4'd6) && (w_v <= 4'd7);
      default:          o_draw = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/baccarat_round_ctrl.sv
// ============================================================================
// Module : baccarat_round_ctrl
// Brief  : Full-round baccarat sequencer (deal, naturals, third-card rules, result).
//          Define BACCARAT_AUTO_DEAL_EN to leave IDLE without waiting for deal.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baccarat_round_ctrl
  import baccarat_pkg::*;
#(
  parameter int NAT_MIN  = NAT_MIN_DEF,
  parameter int DRAW_MAX = DRAW_MAX_DEF
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       deal,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       busy
);

  localparam logic [3:0] c_nat_min  = NAT_MIN[3:0];
  localparam logic [3:0] c_draw_max = DRAW_MAX[3:0];

  state_t r_state;
  state_t w_next;
  logic   w_bank_draw;
  logic   w_start;

  banker_draw_rule u_bank_rule (
    .i_dscore (dscore),
    .i_pcard3 (pcard3),
    .o_draw   (w_bank_draw)
  );

`ifdef BACCARAT_AUTO_DEAL_EN
  assign w_start = 1'b1;
`else
  assign w_start = deal;
`endif

  always_ff @(posedge slow_clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_next = P1;
      P1:   w_next = D1;
      D1:   w_next = P2;
      P2:   w_next = D2;
      D2:   w_next = EVAL;
      EVAL: begin
        if ((pscore >= c_nat_min) || (dscore >= c_nat_min)) w_next = DONE;
        else if (pscore <= c_draw_max)                       w_next = P3;
        else if (dscore <= c_draw_max)                       w_next = D3;
        else                                                 w_next = DONE;
      end
      P3:   w_next = BCHK;
      BCHK: w_next = w_bank_draw ? D3 : DONE;
      D3:   w_next = DONE;
      DONE: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Win lights are the only outputs that look at inputs, and only in DONE.
  always_comb begin
    load_pcard1      = (r_state == P1);
    load_dcard1      = (r_state == D1);
    load_pcard2      = (r_state == P2);
    load_dcard2      = (r_state == D2);
    load_pcard3      = (r_state == P3);
    load_dcard3      = (r_state == D3);
    busy             = (r_state != IDLE) && (r_state != DONE);
    player_win_light = (r_state == DONE) && (pscore >= dscore);
    dealer_win_light = (r_state == DONE) && (dscore >= pscore);
  end

endmodule

`default_nettype wire

// File: tb/tb_baccarat_round_ctrl.sv
// ============================================================================
// Module : tb_baccarat_round_ctrl
// Brief  : Self-checking bench for baccarat_round_ctrl with an expected-output queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baccarat_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       deal = 1'b0;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic       lp1, lp2, lp3, ld1, ld2, ld3, pwin, dwin, busy;
  logic [3:0] r_ds = '0, r_rank = '0;
  logic       w_rule;

  int n_assert = 0;
  int n_fail   = 0;
  logic [6:0] q_exp[$];

  // {busy, lp1, ld1, lp2, ld2, lp3, ld3}
  localparam logic [6:0] V_P1 = 7'b1100000, V_D1 = 7'b1010000, V_P2 = 7'b1001000,
                         V_D2 = 7'b1000100, V_EV = 7'b1000000, V_P3 = 7'b1000010,
                         V_BC = 7'b1000000, V_D3 = 7'b1000001, V_ID = 7'b0000000;

  baccarat_round_ctrl dut (
    .slow_clock       (clk),
    .reset            (rst),
    .deal             (deal),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (lp1),
    .load_pcard2      (lp2),
    .load_pcard3      (lp3),
    .load_dcard1      (ld1),
    .load_dcard2      (ld2),
    .load_dcard3      (ld3),
    .player_win_light (pwin),
    .dealer_win_light (dwin),
    .busy             (busy)
  );

  banker_draw_rule u_rule (.i_dscore(r_ds), .i_pcard3(r_rank), .o_draw(w_rule));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] obs_vec();
    return {busy, lp1, ld1, lp2, ld2, lp3, ld3};
  endfunction

  // Punto banco tableau written as a per-score list of drawing third-card values.
  function automatic logic exp_bank(input int d, input int rank);
    int v;
    v = (rank >= 10) ? 0 : rank;
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d == 4) return v inside {2, 3, 4, 5, 6, 7};
    if (d == 5) return v inside {4, 5, 6, 7};
    if (d == 6) return v inside {6, 7};
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_round(input int p, input int d, input int rank);
    q_exp.push_back(V_P1); q_exp.push_back(V_D1);
    q_exp.push_back(V_P2); q_exp.push_back(V_D2);
    q_exp.push_back(V_EV);
    if (p >= 8 || d >= 8) begin
    end else if (p <= 5) begin
      q_exp.push_back(V_P3); q_exp.push_back(V_BC);
      if (exp_bank(d, rank)) q_exp.push_back(V_D3);
    end else if (d <= 5) begin
      q_exp.push_back(V_D3);
    end
    q_exp.push_back(V_ID);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check(tag, {pwin, dwin, obs_vec()}, {2'b00, V_ID});
    rst = 1'b0;
  endtask

  task automatic run_round(input string tag, input int p, input int d, input int rank,
                           input int pf, input int df);
    int cyc;
    logic [6:0] e;
    pscore = 4'(p); dscore = 4'(d); pcard3 = 4'(rank);
    push_round(p, d, rank);
    deal = 1'b1;
    cyc = 0;
    while (q_exp.size() > 0) begin
      @(negedge clk);
      deal = 1'b0;
      cyc++;
      e = q_exp.pop_front();
      check($sformatf("%s_c%0d", tag, cyc), {2'b00, obs_vec()}, {2'b00, e});
    end
    deal = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    check({tag, "_hold"}, {2'b00, obs_vec()}, {2'b00, V_ID});
    pscore = 4'(pf); dscore = 4'(df);
    #1;
    check({tag, "_lights"}, {7'b0, pwin, dwin}, {7'b0, 1'(pf >= df), 1'(df >= pf)});
  endtask

  initial begin
    for (int d = 0; d < 10; d++) begin
      for (int r = 0; r < 14; r++) begin
        r_ds = 4'(d); r_rank = 4'(r);
        #1;
        check($sformatf("rule_d%0d_r%0d", d, r), {8'b0, w_rule}, {8'b0, exp_bank(d, r)});
      end
    end

    do_reset("rst0");
    @(negedge clk);
`ifdef BACCARAT_AUTO_DEAL_EN
    check("idle_wait", {2'b00, obs_vec()}, {2'b00, V_P1});
`else
    check("idle_wait", {2'b00, obs_vec()}, {2'b00, V_ID});
`endif

    do_reset("rst1");
    run_round("natural", 8, 3, 0, 8, 3);
    do_reset("rst2");
    run_round("stand", 7, 6, 0, 7, 6);
    do_reset("rst3");
    run_round("stand_tie", 6, 6, 0, 6, 6);
    do_reset("rst4");
    run_round("both_draw", 3, 4, 5, 8, 2);
    do_reset("rst5");
    run_round("p_only_face", 2, 6, 12, 2, 6);
    do_reset("rst6");
    run_round("p_only_8", 1, 3, 8, 9, 3);
    do_reset("rst7");
    run_round("d_only", 6, 5, 0, 6, 9);
    do_reset("rst8");
    run_round("bank7_stand", 0, 7, 1, 5, 7);

    // Reset arriving while the player third card is being loaded.
    do_reset("rst9");
    pscore = 4'd3; dscore = 4'd4; pcard3 = 4'd5;
    push_round(3, 4, 5);
    deal = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      logic [6:0] e;
      @(negedge clk);
      deal = 1'b0;
      e = q_exp.pop_front();
      check($sformatf("pre_rst_c%0d", i), {2'b00, obs_vec()}, {2'b00, e});
    end
    q_exp.delete();
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_p3", {pwin, dwin, obs_vec()}, {2'b00, V_ID});
    rst = 1'b0;
    run_round("redeal", 3, 4, 5, 8, 2);

    // deal held across reset: IDLE on the reset edge, P1 on the next.
    @(negedge clk);
    rst = 1'b1; deal = 1'b1;
    @(negedge clk);
    check("deal_hold_rst", {pwin, dwin, obs_vec()}, {2'b00, V_ID});
    rst = 1'b0;
    @(negedge clk);
    check("deal_hold_p1", {2'b00, obs_vec()}, {2'b00, V_P1});
    deal = 1'b0;
    do_reset("rst_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
